// File: rtl/latch_q_edge_counter.sv
// latch_q_edge_counter
// Synchronises the asynchronous latch Q output and debounces it into a clean
// level. Emits one-cycle rise/fall pulses and keeps a saturating count of
// accepted rising edges.
module latch_q_edge_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int TW = $clog2(DEB_CYCLES) + 1;
  localparam logic [TW-1:0]    T_LAST  = TW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]    T_ONE   = TW'(1);
  localparam logic [TW-1:0]    T_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    CHK_HI = 2'd1,
    ST_HI  = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;

  state_t           state_reg,  state_next;
  logic [TW-1:0]    timer_reg,  timer_next;
  logic             level_reg,  level_next;
  logic             rise_reg,   rise_next;
  logic             fall_reg,   fall_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             sat_reg,    sat_next;

  // Shift chain that brings q_in into the clk domain; s is the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], q_in};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

  // State register for the debounce FSM, its timer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_LO;
      timer_reg <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
      count_reg <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
      count_reg <= count_next;
      sat_reg   <= sat_next;
    end
  end

  // Debounce: a change is accepted only after DEB_CYCLES equal samples; any
  // reversion during the check window drops back silently.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ST_LO: begin
        if (s) begin
          state_next = CHK_HI;
          timer_next = T_ONE;
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_next = ST_LO;
          timer_next = T_ZERO;
        end else if (timer_reg == T_LAST) begin
          state_next = ST_HI;
          timer_next = T_ZERO;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          timer_next = timer_reg + T_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          state_next = CHK_LO;
          timer_next = T_ONE;
        end
      end
      CHK_LO: begin
        if (s) begin
          state_next = ST_HI;
          timer_next = T_ZERO;
        end else if (timer_reg == T_LAST) begin
          state_next = ST_LO;
          timer_next = T_ZERO;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          timer_next = timer_reg + T_ONE;
        end
      end
      default: begin
        state_next = ST_LO;
        timer_next = T_ZERO;
        level_next = 1'b0;
      end
    endcase
  end

  // Saturating rise counter; a clear coinciding with a rise still counts it.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = rise_next ? CNT_ONE : '0;
    end else if (rise_next && (count_reg != CNT_MAX)) begin
      count_next = count_reg + CNT_ONE;
    end
    sat_next = (count_next == CNT_MAX);
  end

  assign level = level_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;
  assign count = count_reg;
  assign sat   = sat_reg;

endmodule

// File: tb/tb_latch_q_edge_counter.sv
// Scoreboard bench: stimulus pushes expected pulse events, per-DUT monitors
// pop and compare whenever a rise/fall pulse is presented.
`timescale 1ns/1ns
module tb_latch_q_edge_counter;

  logic clk = 1'b0;
  logic rst, clr, q_a, q_b;
  logic level8, rise8, fall8, sat8;
  logic [7:0] count8;
  logic level3, rise3, fall3, sat3;
  logic [2:0] count3;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit is_rise;
    int cyc;
    int cnt;
    bit sat;
  } ev_t;

  ev_t q8[$];
  ev_t q3[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  latch_q_edge_counter dut8 (
    .clk(clk), .rst(rst), .q_in(q_a), .clr(clr),
    .level(level8), .rise(rise8), .fall(fall8), .count(count8), .sat(sat8)
  );

  latch_q_edge_counter #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .q_in(q_b), .clr(clr),
    .level(level3), .rise(rise3), .fall(fall3), .count(count3), .sat(sat3)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push8(input bit r, input int c, input int n, input bit s);
    ev_t e;
    e.is_rise = r; e.cyc = c; e.cnt = n; e.sat = s;
    q8.push_back(e);
  endtask

  task automatic push3(input bit r, input int c, input int n, input bit s);
    ev_t e;
    e.is_rise = r; e.cyc = c; e.cnt = n; e.sat = s;
    q3.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the 8-bit counter instance.
  always @(negedge clk) begin
    ev_t e;
    while (q8.size() > 0 && q8[0].cyc < cyc) begin
      e = q8.pop_front();
      chk("dut8 missed pulse at cycle", cyc, e.cyc);
    end
    if (!rst && (rise8 || fall8)) begin
      chk("dut8 rise&fall exclusive", int'(rise8 && fall8), 0);
      if (q8.size() == 0) begin
        chk("dut8 unexpected pulse (rise)", int'(rise8), -1);
      end else begin
        e = q8.pop_front();
        chk("dut8 pulse rise", int'(rise8), int'(e.is_rise));
        chk("dut8 pulse cycle", cyc, e.cyc);
        chk("dut8 pulse count", int'(count8), e.cnt);
        chk("dut8 pulse sat", int'(sat8), int'(e.sat));
        chk("dut8 pulse level", int'(level8), int'(e.is_rise));
      end
    end
  end

  // Monitor for the 3-bit counter instance.
  always @(negedge clk) begin
    ev_t e;
    while (q3.size() > 0 && q3[0].cyc < cyc) begin
      e = q3.pop_front();
      chk("dut3 missed pulse at cycle", cyc, e.cyc);
    end
    if (!rst && (rise3 || fall3)) begin
      chk("dut3 rise&fall exclusive", int'(rise3 && fall3), 0);
      if (q3.size() == 0) begin
        chk("dut3 unexpected pulse (rise)", int'(rise3), -1);
      end else begin
        e = q3.pop_front();
        chk("dut3 pulse rise", int'(rise3), int'(e.is_rise));
        chk("dut3 pulse cycle", cyc, e.cyc);
        chk("dut3 pulse count", int'(count3), e.cnt);
        chk("dut3 pulse sat", int'(sat3), int'(e.sat));
        chk("dut3 pulse level", int'(level3), int'(e.is_rise));
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; q_a = 1'b1; q_b = 1'b0;

    // 1: reset held with q_in high, then release
    wait_neg(1);
    chk("rst level8", int'(level8), 0);
    chk("rst rise8", int'(rise8), 0);
    chk("rst fall8", int'(fall8), 0);
    chk("rst count8", int'(count8), 0);
    chk("rst sat8", int'(sat8), 0);
    chk("rst level3", int'(level3), 0);
    chk("rst count3", int'(count3), 0);
    chk("rst sat3", int'(sat3), 0);
    wait_neg(1);
    rst = 1'b0;
    push8(1'b1, cyc + 6, 1, 1'b0);
    wait_neg(10);
    q_a = 1'b0;
    push8(1'b0, cyc + 6, 1, 1'b0);
    wait_neg(10);

    // 2: clean 0->1 step held 100 ns
    q_a = 1'b1;
    push8(1'b1, cyc + 6, 2, 1'b0);
    wait_neg(10);
    chk("t2 level8 high", int'(level8), 1);
    q_a = 1'b0;
    push8(1'b0, cyc + 6, 2, 1'b0);
    wait_neg(10);

    // 3: short pulses are rejected
    q_a = 1'b1; wait_neg(2); q_a = 1'b0; wait_neg(10);
    chk("t3 20ns level8", int'(level8), 0);
    chk("t3 20ns count8", int'(count8), 2);
    q_a = 1'b1; wait_neg(3); q_a = 1'b0; wait_neg(10);
    chk("t3 30ns level8", int'(level8), 0);
    chk("t3 30ns count8", int'(count8), 2);

    // 4: saturation on the 3-bit instance
    for (int k = 1; k <= 9; k++) begin
      q_b = 1'b1;
      push3(1'b1, cyc + 6, (k > 7) ? 7 : k, k >= 7);
      wait_neg(8);
      q_b = 1'b0;
      push3(1'b0, cyc + 6, (k > 7) ? 7 : k, k >= 7);
      wait_neg(8);
    end
    chk("t4 count3 held", int'(count3), 7);
    chk("t4 sat3", int'(sat3), 1);

    // 5: clr coinciding with a rise commit, then clr alone
    q_a = 1'b1;
    push8(1'b1, cyc + 6, 1, 1'b0);
    wait_neg(5);
    clr = 1'b1;
    wait_neg(1);
    clr = 1'b0;
    chk("t5 count3 cleared", int'(count3), 0);
    chk("t5 sat3 cleared", int'(sat3), 0);
    wait_neg(4);
    chk("t5 count8 after clr+rise", int'(count8), 1);
    clr = 1'b1;
    wait_neg(1);
    clr = 1'b0;
    chk("t5 count8 after clr", int'(count8), 0);
    chk("t5 sat8 after clr", int'(sat8), 0);
    chk("t5 level8 unaffected", int'(level8), 1);
    q_a = 1'b0;
    push8(1'b0, cyc + 6, 0, 1'b0);
    wait_neg(10);

    // 6: reset asserted while the rise is being checked
    q_a = 1'b1; q_b = 1'b1;
    push8(1'b1, cyc + 6, 1, 1'b0);
    push3(1'b1, cyc + 6, 1, 1'b0);
    wait_neg(10);
    q_a = 1'b0; q_b = 1'b0;
    push8(1'b0, cyc + 6, 1, 1'b0);
    push3(1'b0, cyc + 6, 1, 1'b0);
    wait_neg(10);
    q_a = 1'b1;
    wait_neg(4);
    #2 rst = 1'b1;
    #1;
    chk("t6 async count8", int'(count8), 0);
    chk("t6 async count3", int'(count3), 0);
    chk("t6 async level8", int'(level8), 0);
    chk("t6 async rise8", int'(rise8), 0);
    wait_neg(2);
    rst = 1'b0;
    push8(1'b1, cyc + 6, 1, 1'b0);
    wait_neg(10);
    chk("t6 resume level8", int'(level8), 1);
    q_a = 1'b0;
    push8(1'b0, cyc + 6, 1, 1'b0);
    wait_neg(10);

    chk("scoreboard8 drained", q8.size(), 0);
    chk("scoreboard3 drained", q3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
